// File: rtl/blk_mem_gen_rom_pkg.sv
// Shared constants and content tables for the operand ROMs of the display datapath.
package blk_mem_gen_pkg;

    localparam int ROM_ADDR_W = 3;
    localparam int ROM_DATA_W = 18;
    localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

    typedef logic [ROM_DATA_W-1:0] rom_word_t;

    localparam rom_word_t ROM_DEFAULT_INIT [0:ROM_DEPTH-1] = '{
        18'd12, 18'd34, 18'd56, 18'd78, 18'd90, 18'd123, 18'd456, 18'd789
    };

    // Selector 1 is the all-zero table; any other selector falls back to the default table.
    function automatic rom_word_t rom_init(input int sel, input int idx);
        if (sel == 1 || idx < 0 || idx >= ROM_DEPTH) begin
            return '0;
        end
        return ROM_DEFAULT_INIT[idx[ROM_ADDR_W-1:0]];
    endfunction

endpackage

// File: rtl/blk_mem_gen_rom.sv
// Single-port synchronous ROM with registered output; defining BLK_MEM_OUT_REG_EN
// adds a second output register (read latency 2 instead of 1).
module blk_mem_gen_rom
    import blk_mem_gen_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 18,
    parameter int INIT_SEL = 0
) (
    input  logic              clka,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] douta
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are constants; the cast zero-extends or truncates each entry to DATA_W.
    for (genvar i = 0; i < DEPTH; i++) begin : g_init
        assign mem[i] = DATA_W'(rom_init(INIT_SEL, i));
    end

    logic [DATA_W-1:0] rd_p0;

    // stage 0: array read register
    always_ff @(posedge clka) begin
        if (reset) begin
            rd_p0 <= '0;
        end else begin
            rd_p0 <= mem[addra];
        end
    end

`ifdef BLK_MEM_OUT_REG_EN
    logic [DATA_W-1:0] rd_p1;

    // stage 1: extra output register
    always_ff @(posedge clka) begin
        if (reset) begin
            rd_p1 <= '0;
        end else begin
            rd_p1 <= rd_p0;
        end
    end

    assign douta = rd_p1;
`else
    assign douta = rd_p0;
`endif

endmodule

// File: tb/tb_blk_mem_gen_rom.sv
// Bench for blk_mem_gen_rom: directed vector table, a reset corner sequence and random reads.
module tb_blk_mem_gen_rom;

`ifdef BLK_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  addra = '0;
    logic [17:0] douta;
    logic [17:0] douta_z;

    int compared = 0;
    int mismatched = 0;

    blk_mem_gen_rom #(.ADDR_W(3), .DATA_W(18), .INIT_SEL(0)) dut (
        .clka (clk),
        .reset(reset),
        .addra(addra),
        .douta(douta)
    );

    blk_mem_gen_rom #(.ADDR_W(3), .DATA_W(18), .INIT_SEL(1)) dut_zero (
        .clka (clk),
        .reset(reset),
        .addra(addra),
        .douta(douta_z)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        logic [2:0]  addr;
        logic [17:0] word;
    } vec_t;

    vec_t vecs[$];

    // Reference: contents straight from the table, and the full input history.
    int ref_mem [8] = '{12, 34, 56, 78, 90, 123, 456, 789};
    bit         hist_rst[$];
    logic [2:0] hist_addr[$];

    // Output after the latest edge: zero if any of the last LAT edges saw reset
    // (or precede the start of the run), else the word addressed LAT-1 edges ago.
    function automatic logic [17:0] model_out();
        int last = hist_rst.size() - 1;
        for (int k = 0; k < LAT; k++) begin
            if (last - k < 0) return '0;
            if (hist_rst[last - k]) return '0;
        end
        return 18'(ref_mem[hist_addr[last - LAT + 1]]);
    endfunction

    task automatic add_vec(input bit r, input logic [2:0] a, input int w);
        vec_t v;
        v.rst = r;
        v.addr = a;
        v.word = 18'(w);
        vecs.push_back(v);
    endtask

    task automatic step(input bit r, input logic [2:0] a);
        reset = r;
        addra = a;
        @(posedge clk);
        hist_rst.push_back(r);
        hist_addr.push_back(a);
        #1;
    endtask

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [17:0] exp;
        bit          r;
        logic [2:0]  a;

        for (int i = 0; i < 3; i++) add_vec(1'b1, 3'd5, 0);
        add_vec(1'b0, 3'd0, 12);
        add_vec(1'b0, 3'd1, 34);
        add_vec(1'b0, 3'd2, 56);
        add_vec(1'b0, 3'd3, 78);
        add_vec(1'b0, 3'd4, 90);
        add_vec(1'b0, 3'd5, 123);
        add_vec(1'b0, 3'd6, 456);
        add_vec(1'b0, 3'd7, 789);
        add_vec(1'b0, 3'd7, 789);
        add_vec(1'b0, 3'd0, 12);
        for (int i = 0; i < 5; i++) add_vec(1'b0, 3'd3, 78);
        add_vec(1'b0, 3'd6, 456);
        add_vec(1'b0, 3'd6, 456);
        add_vec(1'b1, 3'd6, 0);
        add_vec(1'b0, 3'd6, 456);
        add_vec(1'b0, 3'd6, 456);
        add_vec(1'b0, 3'd6, 456);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].addr);
            exp = (i - LAT + 1 >= 0) ? vecs[i - LAT + 1].word : 18'd0;
            for (int k = 0; k < LAT; k++) begin
                if (i - k < 0 || vecs[i - k].rst) exp = '0;
            end
            check($sformatf("table[%0d]", i), douta, exp);
            check($sformatf("zero_table[%0d]", i), douta_z, 18'd0);
        end

        // Reset pulse in the middle of a steady read of address 6.
        for (int i = 0; i < 3; i++) step(1'b0, 3'd6);
        check("hold6", douta, 18'd456);
        step(1'b1, 3'd6);
        check("midreset", douta, 18'd0);
        for (int k = 1; k <= LAT; k++) begin
            step(1'b0, 3'd6);
            check($sformatf("resume+%0d", k), douta, (k < LAT) ? 18'd0 : 18'd456);
        end

        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            a = 3'($urandom_range(0, 7));
            step(r, a);
            check($sformatf("rand[%0d]", i), douta, model_out());
            check($sformatf("rand_zero[%0d]", i), douta_z, 18'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/blk_mem_gen_rom.md
Name: blk_mem_gen_rom

Overview:
Single-port synchronous read-only memory: 8 words x 18 bits, with a registered output.
Used as the operand source for the arithmetic datapath in the display top level.
- Three instances, for operands a, b and c, share one address counter.
- That counter advances once per display period.
Contents are fixed at elaboration; there is no write port.

Parameters:
ADDR_W, 3, address width; depth = 2**ADDR_W words.
DATA_W, 18, word width in bits.
INIT_SEL, 0, content table select.
- 0 = default table from the package.
- 1 = all-zero table.
- Any other value behaves as 0.

Ports:
clka  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
addra  input  ADDR_W  read address.
douta  output  DATA_W  read data, registered.

Behaviour:
Clocking and reset:
- One clock (clka). Reset is synchronous and active-high, named reset.
- Reset is sampled only on the rising clka edge.
- When reset=1 at a clka edge, douta <= 0 on that edge, regardless of addra.
Read:
- Every clka edge with reset=0: douta <= MEM[addra].
- Read latency is 1 cycle: the address presented before edge N appears on douta after edge N.
- douta holds its value between edges. There is no enable, so a read occurs every cycle.
Memory array:
- Array MEM[0..2**ADDR_W-1] of DATA_W bits.
- Initialised at elaboration from the table selected by INIT_SEL.
- Never modified at run time. Reset clears only the output register, not the contents.
Default table (INIT_SEL=0), address: value (decimal):
- 0: 12
- 1: 34
- 2: 56
- 3: 78
- 4: 90
- 5: 123
- 6: 456
- 7: 789
Width rules:
- Table entries are zero-extended to DATA_W.
- If ADDR_W > 3, addresses 8 and above read 0.
- Values wider than DATA_W are truncated to the low DATA_W bits.
Boundary conditions:
- Address wrap (7 -> 0) is the caller's concern. This block reads whatever address is presented.
- Reset asserted mid-stream: douta is 0 on that edge. Normal reads resume on the first edge with reset=0.
- Power-up: douta has no defined value until the first edge. With the initial-value policy, douta initialises to 0.
- X or Z on addra: not supported; simulation may produce X on douta.

Optional Feature:
Macro BLK_MEM_OUT_REG_EN.
- Defined:
  - A second output register is added after the array read register.
  - Read latency becomes 2 cycles.
  - Both registers clear to 0 on reset.
  - douta is driven from the second register.
- Undefined: single register, latency 1.
Everything else is identical in both builds: port list, contents and reset behaviour.

Decomposition:
Package blk_mem_gen_pkg contains:
- Localparams ROM_ADDR_W=3 and ROM_DATA_W=18.
- Typedef rom_word_t, DATA_W bits.
- Constant array ROM_DEFAULT_INIT[0:7] holding the table above.
- Function rom_init(sel, idx), returning the table entry for the given selector and index.
No sub-module is needed; the array and the output register(s) live in a single module.

Test Plan:
1. Reset: hold reset=1 for 3 edges with addra=5 -> douta=0 after each edge.
2. Sequential read: release reset, drive addra=0..7 on consecutive cycles -> douta is 12, 34, 56, 78, 90, 123, 456, 789, each one edge after its address.
3. Wrap and hold:
   - Drive addra=7 then 0 -> douta goes 789 then 12.
   - Hold addra=3 for 5 edges -> douta stays 78.
4. Mid-stream reset: reading addr 6 (douta=456), assert reset for one edge -> douta=0; next edge with addra=6 -> 456.
5. BLK_MEM_OUT_REG_EN defined, addra=0..7 -> each value appears two edges after its address; after reset both stages read 0.
6. INIT_SEL=1 -> all 8 addresses read 0.
